mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Parametrised top-level mode sequencer for the digital piano: generalises the hard-wired menu/mode controller to MODES selectable modes, with synchronised submit/cancel edge detection, strict one-hot key validation, a per-mode done handshake, an idle timeout that returns to menu, and the shared tick/system-time counter. It sits directly under the board top. It drives one-hot enables and a select index into the per-mode blocks and the output muxes.

## Interface
- MODES, 5: number of selectable modes (1..KEY_W).
- KEY_W, 7: width of the note key bus.
- TICK_DIV, 100000: clk cycles per tick (100 MHz -> 1 ms).
- TIMEOUT_TICKS, 30000: idle ticks in RUN before auto-exit; 0 disables the timeout.
- SEL_W, $clog2(MODES+1): select width (derived, not overridden).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- submit  in  1  raw confirm button level.
- cancel  in  1  raw back button level.
- key  in  KEY_W  raw note key switches, used as the mode selector.
- mode_busy  in  MODES  mode i is mid-operation; suppresses the timeout.
- mode_done  in  MODES  mode i requests return to menu (level or pulse).
- mode_en  out  MODES  one-hot enable of the active mode; all zero outside RUN.
- mode_sel  out  SEL_W  0 = menu, i+1 = mode i active; drives the output muxes.
- preview  out  SEL_W  menu highlight: index+1 of a valid key, else 0.
- key_err  out  1  one-cycle pulse on submit with an invalid key.
- submit_p  out  1  one-cycle synchronised submit edge, forwarded to the modes.
- tick  out  1  one-cycle pulse every TICK_DIV clk cycles.
- sys_time  out  16  tick counter; wraps from 0xFFFF to 0.

## Operation
- All outputs reset to 0. State resets to MENU. All counters and sync flops reset to 0.
- submit, cancel and key pass through a 2-flop synchroniser. The submit/cancel pulse is sync2 & ~sync3.
- Key valid: exactly one bit set, at index i < MODES. Zero bits, multiple bits, or an index >= MODES is invalid.
- MENU:
  - preview tracks the key.
  - A submit edge with a valid key sets mode_sel = i+1 and mode_en = 1<<i, then goes to RUN.
  - A submit edge with an invalid key pulses key_err and stays in MENU.
  - A cancel edge is ignored.
- RUN:
  - A cancel edge, mode_done[i], or the idle count reaching TIMEOUT_TICKS goes to EXIT.
  - Submit edges are forwarded on submit_p. They do not reselect the mode.
  - preview = mode_sel.
- EXIT:
  - Lasts exactly one cycle with mode_en = 0 while mode_sel still holds its value. This gives each mode a guaranteed enable-low cycle.
  - Then goes to MENU with mode_sel = 0.
  - Edges arriving during EXIT are dropped.
- Simultaneous events:
  - In MENU, cancel beats submit: neither is acted on.
  - In RUN, cancel, done and timeout are equivalent. Any one of them exits.
- Idle counter:
  - Counts ticks in RUN.
  - Clears on entry to RUN, on a submit edge, on any change of the synchronised key, and while mode_busy[i] = 1.
  - Saturates at TIMEOUT_TICKS.
- mode_done and mode_busy of inactive modes are ignored.
- Tick divider: counts 0..TICK_DIV-1 and pulses tick at the wrap. sys_time increments on each tick. Both run in every state.

## Timing
- Raw submit rising at cycle 0 (setup met) gives submit_p at cycle 3. In MENU, mode_en and mode_sel are registered at cycle 4.
- mode_done[i] high at cycle n gives EXIT at n+1 (mode_en = 0) and MENU at n+2 (mode_sel = 0).
- key_err is registered alongside the submit decision, at cycle 4.
- preview has 3-cycle latency from the raw key (2 sync stages plus 1 register).
- Reset mid-RUN takes effect asynchronously: mode_en = 0 immediately, with no EXIT cycle.

## Structure
- The shared constants header holds the state encoding (MENU=0, RUN=1, EXIT=2, 2 bits) and the default TICK_DIV.
- One sub-module, edge_sync: 2-flop synchroniser plus rising-edge pulse. It is instantiated for submit and for cancel.
- Key validation is an onehot-and-range function inside mode_sequencer.

## Test plan
- MODES=5, TICK_DIV=4: key=7'b0000100, raise submit. Required: mode_en=5'b00100 and mode_sel=3 at cycle 4.
- Submit with key=7'b0000110, then with key=7'b0100000 (index 5 >= MODES). Required: a key_err pulse for each, state stays MENU, mode_en=0.
- In RUN mode 0, pulse mode_done[0]. Required: mode_en=0 with mode_sel=1 for 1 cycle, then mode_sel=0. mode_done[3] alone has no effect.
- TICK_DIV=4, TIMEOUT_TICKS=3, RUN with busy=0. Required: EXIT after 12 clk of idle. With mode_busy[i]=1 held, no exit after 100 clk.
- Submit and cancel rising in the same cycle in MENU. Required: no transition and no key_err.
- Assert rst mid-RUN. Required: all outputs 0 asynchronously. Run sys_time for 65536 ticks: required wrap to 0.

Source files
------------

// File: rtl/mode_sequencer_pkg.sv
// Shared constants for the mode sequencer: FSM encoding and default tick divider.
package mode_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXIT = 2'd2
  } state_t;

  // 100 MHz system clock divided down to a 1 ms tick
  localparam int unsigned DEFAULT_TICK_DIV = 100000;

endpackage

// File: rtl/mode_sequencer_edge_sync.sv
// Two-flop synchroniser for a raw button level plus a registered rising-edge pulse.
module mode_sequencer_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchronise the raw level and register a one-cycle pulse on its rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      sync3 <= sync2;
      pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Menu/mode controller: selects one of MODES blocks from a one-hot key, runs it
// until cancel, done or idle timeout, and keeps the shared tick / system time.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter  int unsigned MODES         = 5,
  parameter  int unsigned KEY_W         = 7,
  parameter  int unsigned TICK_DIV      = DEFAULT_TICK_DIV,
  parameter  int unsigned TIMEOUT_TICKS = 30000,
  localparam int unsigned SEL_W         = $clog2(MODES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             submit,
  input  logic             cancel,
  input  logic [KEY_W-1:0] key,
  input  logic [MODES-1:0] mode_busy,
  input  logic [MODES-1:0] mode_done,
  output logic [MODES-1:0] mode_en,
  output logic [SEL_W-1:0] mode_sel,
  output logic [SEL_W-1:0] preview,
  output logic             key_err,
  output logic             submit_p,
  output logic             tick,
  output logic [15:0]      sys_time
);

  localparam int unsigned DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned IDLE_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  // Mode code of a key: index+1 when exactly one bit is set below MODES, else 0
  function automatic logic [SEL_W-1:0] key_code(input logic [KEY_W-1:0] k);
    logic [SEL_W-1:0] code;
    code = '0;
    if ($onehot(k)) begin
      for (int i = 0; i < int'(MODES); i++) begin
        if (k[i]) code = SEL_W'(i + 1);
      end
    end
    return code;
  endfunction

  state_t state_q;
  state_t state_d;

  logic [KEY_W-1:0]  key_s1;
  logic [KEY_W-1:0]  key_s2;
  logic [KEY_W-1:0]  key_s3;
  logic              cancel_p;
  logic [SEL_W-1:0]  key_code_c;
  logic              key_ok_c;
  logic              done_act_c;
  logic              busy_act_c;
  logic              timeout_c;
  logic              exit_c;
  logic              act_c;
  logic [IDLE_W-1:0] idle_q;
  logic [DIV_W-1:0]  div_q;

  logic [MODES-1:0]  mode_en_d;
  logic [SEL_W-1:0]  mode_sel_d;
  logic [SEL_W-1:0]  preview_d;
  logic              key_err_d;

  mode_sequencer_edge_sync u_submit_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (submit),
    .pulse (submit_p)
  );

  mode_sequencer_edge_sync u_cancel_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (cancel),
    .pulse (cancel_p)
  );

  // Key synchroniser; the third stage only feeds change detection for the idle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_s3 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  // Qualified events: only the active mode's done/busy count, and cancel wins over submit in MENU
  always_comb begin
    key_code_c = key_code(key_s2);
    key_ok_c   = |key_code_c;
    done_act_c = |(mode_done & mode_en);
    busy_act_c = |(mode_busy & mode_en);
    timeout_c  = (TIMEOUT_TICKS != 0) && (idle_q == IDLE_W'(TIMEOUT_TICKS));
    exit_c     = cancel_p | done_act_c | timeout_c;
    act_c      = submit_p & ~cancel_p;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_MENU;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MENU: if (act_c && key_ok_c) state_d = ST_RUN;
      ST_RUN:  if (exit_c)            state_d = ST_EXIT;
      ST_EXIT:                        state_d = ST_MENU;
      default:                        state_d = ST_MENU;
    endcase
  end

  // Next values of the registered outputs; EXIT drops the enable one cycle before the select
  always_comb begin
    mode_en_d  = mode_en;
    mode_sel_d = mode_sel;
    preview_d  = preview;
    key_err_d  = 1'b0;
    case (state_q)
      ST_MENU: begin
        preview_d = key_code_c;
        if (act_c) begin
          if (key_ok_c) begin
            mode_en_d  = key_s2[MODES-1:0];
            mode_sel_d = key_code_c;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        preview_d = mode_sel;
        if (exit_c) mode_en_d = '0;
      end
      ST_EXIT: begin
        mode_en_d  = '0;
        mode_sel_d = '0;
        preview_d  = '0;
      end
      default: begin
        mode_en_d  = '0;
        mode_sel_d = '0;
        preview_d  = '0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_en  <= '0;
      mode_sel <= '0;
      preview  <= '0;
      key_err  <= 1'b0;
    end else begin
      mode_en  <= mode_en_d;
      mode_sel <= mode_sel_d;
      preview  <= preview_d;
      key_err  <= key_err_d;
    end
  end

  // Idle tick counter for RUN; any user or mode activity restarts it, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q != ST_RUN || submit_p || (key_s2 != key_s3) || busy_act_c) begin
      idle_q <= '0;
    end else if (tick && idle_q != IDLE_W'(TIMEOUT_TICKS)) begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end

  // Free-running tick divider and system time, independent of the FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      tick     <= 1'b0;
      sys_time <= '0;
    end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
      div_q    <= '0;
      tick     <= 1'b1;
      sys_time <= sys_time + 16'd1;
    end else begin
      div_q    <= div_q + DIV_W'(1);
      tick     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: selection, key errors, done/cancel exit,
// idle timeout, busy suppression, simultaneous edges, async reset, sys_time wrap.
module tb_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       submit;
  logic       cancel;
  logic [6:0] key;
  logic [4:0] mode_busy;
  logic [4:0] mode_done;
  logic [4:0] mode_en;
  logic [2:0] mode_sel;
  logic [2:0] preview;
  logic       key_err;
  logic       submit_p;
  logic       tick;
  logic [15:0] sys_time;

  // second instance with a tick every clock, used for the sys_time wrap
  logic       rst2;
  logic       in0;
  logic [6:0] key0;
  logic [4:0] v0;
  logic [4:0] mode_en2;
  logic [2:0] mode_sel2;
  logic [2:0] preview2;
  logic       key_err2;
  logic       submit_p2;
  logic       tick2;
  logic [15:0] sys_time2;

  int pass_cnt;
  int total_cnt;
  int tb_cycles;

  mode_sequencer #(.MODES(5), .KEY_W(7), .TICK_DIV(4), .TIMEOUT_TICKS(3)) dut (
    .clk(clk), .rst(rst), .submit(submit), .cancel(cancel), .key(key),
    .mode_busy(mode_busy), .mode_done(mode_done), .mode_en(mode_en),
    .mode_sel(mode_sel), .preview(preview), .key_err(key_err),
    .submit_p(submit_p), .tick(tick), .sys_time(sys_time)
  );

  mode_sequencer #(.MODES(5), .KEY_W(7), .TICK_DIV(1), .TIMEOUT_TICKS(0)) dut2 (
    .clk(clk), .rst(rst2), .submit(in0), .cancel(in0), .key(key0),
    .mode_busy(v0), .mode_done(v0), .mode_en(mode_en2),
    .mode_sel(mode_sel2), .preview(preview2), .key_err(key_err2),
    .submit_p(submit_p2), .tick(tick2), .sys_time(sys_time2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference count of clock edges since dut2 left reset (one tick per edge)
  always @(posedge clk) begin
    if (rst2) tb_cycles <= 0;
    else      tb_cycles <= tb_cycles + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    submit = 0; cancel = 0; key = '0; mode_busy = '0; mode_done = '0;
    in0 = 0; key0 = '0; v0 = '0;
    step(2);
    total_cnt++; if (mode_en !== 5'b0) $display("FAIL reset_mode_en got %b want 00000", mode_en); else pass_cnt++;
    total_cnt++; if (mode_sel !== 3'd0) $display("FAIL reset_mode_sel got %0d want 0", mode_sel); else pass_cnt++;
    total_cnt++; if (preview !== 3'd0) $display("FAIL reset_preview got %0d want 0", preview); else pass_cnt++;
    total_cnt++; if (key_err !== 1'b0 || submit_p !== 1'b0 || tick !== 1'b0)
      $display("FAIL reset_pulses got %b%b%b want 000", key_err, submit_p, tick); else pass_cnt++;
    total_cnt++; if (sys_time !== 16'd0) $display("FAIL reset_sys_time got %0d want 0", sys_time); else pass_cnt++;
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_tick;
    step(3);
    total_cnt++; if (tick !== 1'b0 || sys_time !== 16'd0)
      $display("FAIL tick_pre got tick=%b t=%0d want 0/0", tick, sys_time); else pass_cnt++;
    step(1);
    total_cnt++; if (tick !== 1'b1 || sys_time !== 16'd1)
      $display("FAIL tick_first got tick=%b t=%0d want 1/1", tick, sys_time); else pass_cnt++;
    step(1);
    total_cnt++; if (tick !== 1'b0) $display("FAIL tick_width got %b want 0", tick); else pass_cnt++;
    step(3);
    total_cnt++; if (tick !== 1'b1 || sys_time !== 16'd2)
      $display("FAIL tick_second got tick=%b t=%0d want 1/2", tick, sys_time); else pass_cnt++;
  endtask

  task automatic test_select;
    key = 7'b0000100; submit = 1;
    step(3);
    total_cnt++; if (submit_p !== 1'b1) $display("FAIL sel_submit_p got %b want 1", submit_p); else pass_cnt++;
    total_cnt++; if (preview !== 3'd3) $display("FAIL sel_preview got %0d want 3", preview); else pass_cnt++;
    total_cnt++; if (mode_en !== 5'b0) $display("FAIL sel_early got %b want 00000", mode_en); else pass_cnt++;
    step(1);
    total_cnt++; if (mode_en !== 5'b00100 || mode_sel !== 3'd3)
      $display("FAIL sel_enter got en=%b sel=%0d want 00100/3", mode_en, mode_sel); else pass_cnt++;
    total_cnt++; if (key_err !== 1'b0 || submit_p !== 1'b0)
      $display("FAIL sel_pulses got err=%b sp=%b want 0/0", key_err, submit_p); else pass_cnt++;
    submit = 0; cancel = 1; key = 7'b0000001;
    step(3);
    total_cnt++; if (preview !== 3'd3) $display("FAIL run_preview got %0d want 3", preview); else pass_cnt++;
    step(1);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd3)
      $display("FAIL cancel_exit got en=%b sel=%0d want 00000/3", mode_en, mode_sel); else pass_cnt++;
    step(1);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL cancel_menu got en=%b sel=%0d want 00000/0", mode_en, mode_sel); else pass_cnt++;
    cancel = 0; key = '0;
    step(4);
  endtask

  task automatic test_key_err;
    key = 7'b0000110; submit = 1;
    step(4);
    total_cnt++; if (key_err !== 1'b1 || mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL err_multi got err=%b en=%b sel=%0d want 1/00000/0", key_err, mode_en, mode_sel); else pass_cnt++;
    step(1);
    total_cnt++; if (key_err !== 1'b0) $display("FAIL err_pulse got %b want 0", key_err); else pass_cnt++;
    submit = 0;
    step(4);
    key = 7'b0100000; submit = 1;
    step(4);
    total_cnt++; if (key_err !== 1'b1 || mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL err_range got err=%b en=%b sel=%0d want 1/00000/0", key_err, mode_en, mode_sel); else pass_cnt++;
    total_cnt++; if (preview !== 3'd0) $display("FAIL err_preview got %0d want 0", preview); else pass_cnt++;
    submit = 0; key = '0;
    step(4);
  endtask

  task automatic test_done;
    key = 7'b0000001; submit = 1;
    step(4);
    total_cnt++; if (mode_en !== 5'b00001 || mode_sel !== 3'd1)
      $display("FAIL done_enter got en=%b sel=%0d want 00001/1", mode_en, mode_sel); else pass_cnt++;
    submit = 0; mode_busy = 5'b00001; mode_done = 5'b01000;
    step(6);
    total_cnt++; if (mode_en !== 5'b00001) $display("FAIL done_inactive got %b want 00001", mode_en); else pass_cnt++;
    mode_done = 5'b00001;
    step(1);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd1)
      $display("FAIL done_exit got en=%b sel=%0d want 00000/1", mode_en, mode_sel); else pass_cnt++;
    mode_done = '0;
    step(1);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL done_menu got en=%b sel=%0d want 00000/0", mode_en, mode_sel); else pass_cnt++;
    mode_busy = '0; key = '0;
    step(4);
  endtask

  task automatic test_timeout;
    int n;
    key = 7'b0000010; submit = 1;
    step(4);
    total_cnt++; if (mode_sel !== 3'd2) $display("FAIL to_enter got %0d want 2", mode_sel); else pass_cnt++;
    submit = 0;
    n = 0;
    while (mode_en !== 5'b0 && n < 20) begin
      step(1);
      n++;
    end
    total_cnt++; if (n < 9 || n > 14) $display("FAIL to_latency got %0d cycles want 9..14", n); else pass_cnt++;
    total_cnt++; if (mode_sel !== 3'd2) $display("FAIL to_exit_sel got %0d want 2", mode_sel); else pass_cnt++;
    step(1);
    total_cnt++; if (mode_sel !== 3'd0) $display("FAIL to_menu got %0d want 0", mode_sel); else pass_cnt++;
    step(4);
  endtask

  task automatic test_busy;
    mode_busy = 5'b00010; key = 7'b0000010; submit = 1;
    step(4);
    submit = 0;
    step(100);
    total_cnt++; if (mode_en !== 5'b00010) $display("FAIL busy_hold got %b want 00010", mode_en); else pass_cnt++;
    cancel = 1;
    step(5);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL busy_cancel got en=%b sel=%0d want 00000/0", mode_en, mode_sel); else pass_cnt++;
    cancel = 0;
    step(4);
    mode_busy = 5'b00100; submit = 1;
    step(4);
    total_cnt++; if (mode_en !== 5'b00010) $display("FAIL busy_other_enter got %b want 00010", mode_en); else pass_cnt++;
    submit = 0;
    step(16);
    total_cnt++; if (mode_sel !== 3'd0) $display("FAIL busy_other_timeout got %0d want 0", mode_sel); else pass_cnt++;
    mode_busy = '0; key = '0;
    step(4);
  endtask

  task automatic test_simultaneous;
    key = 7'b0000100; submit = 1; cancel = 1;
    step(4);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0 || key_err !== 1'b0)
      $display("FAIL simul_valid got en=%b sel=%0d err=%b want 00000/0/0", mode_en, mode_sel, key_err); else pass_cnt++;
    step(1);
    total_cnt++; if (mode_sel !== 3'd0) $display("FAIL simul_late got %0d want 0", mode_sel); else pass_cnt++;
    submit = 0; cancel = 0;
    step(4);
    key = 7'b0000110; submit = 1; cancel = 1;
    step(4);
    total_cnt++; if (key_err !== 1'b0) $display("FAIL simul_err got %b want 0", key_err); else pass_cnt++;
    submit = 0; cancel = 0; key = '0;
    step(4);
  endtask

  task automatic test_async_reset;
    key = 7'b0010000; submit = 1;
    step(4);
    total_cnt++; if (mode_en !== 5'b10000 || mode_sel !== 3'd5)
      $display("FAIL ar_enter got en=%b sel=%0d want 10000/5", mode_en, mode_sel); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0 || preview !== 3'd0)
      $display("FAIL ar_outputs got en=%b sel=%0d pv=%0d want 0/0/0", mode_en, mode_sel, preview); else pass_cnt++;
    total_cnt++; if (sys_time !== 16'd0 || submit_p !== 1'b0)
      $display("FAIL ar_time got t=%0d sp=%b want 0/0", sys_time, submit_p); else pass_cnt++;
    submit = 0; key = '0;
    step(1);
    rst = 1'b0;
    step(4);
    total_cnt++; if (mode_en !== 5'b0 || mode_sel !== 3'd0)
      $display("FAIL ar_after got en=%b sel=%0d want 0/0", mode_en, mode_sel); else pass_cnt++;
  endtask

  task automatic test_sys_time_wrap;
    int guard;
    guard = 0;
    while (tb_cycles < 65535 && guard < 70000) begin
      step(1);
      guard++;
    end
    total_cnt++; if (sys_time2 !== 16'hFFFF) $display("FAIL wrap_top got %h want ffff", sys_time2); else pass_cnt++;
    step(1);
    total_cnt++; if (sys_time2 !== 16'h0000 || tick2 !== 1'b1)
      $display("FAIL wrap_zero got t=%h tick=%b want 0000/1", sys_time2, tick2); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_tick();
    test_select();
    test_key_err();
    test_done();
    test_timeout();
    test_busy();
    test_simultaneous();
    test_async_reset();
    test_sys_time_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
